// File: rtl/mem_bank_ctrl_if.sv
// rtl/mem_bank_ctrl_if.sv - request and SRAM macro-array signal bundle for mem_bank_ctrl
interface mem_bank_ctrl_if #(
    parameter int DATA_W         = 8,
    parameter int MACRO_AW       = 10,
    parameter int MACRO_PER_BANK = 16,
    parameter int NUM_BANKS      = 4,
    parameter int LEN_W          = 4
) ();
    localparam int NM     = NUM_BANKS * MACRO_PER_BANK;
    localparam int ADDR_W = MACRO_AW + $clog2(NM);

    logic                 REQ_VALID;
    logic                 REQ_READY;
    logic                 REQ_WE;
    logic [ADDR_W-1:0]    REQ_ADDR;
    logic [LEN_W-1:0]     REQ_LEN;
    logic [DATA_W-1:0]    REQ_WDATA;
    logic                 BEAT_ACK;
    logic                 BUSY;
    logic [MACRO_AW-1:0]  MEM_ADDR;
    logic                 MEM_CE;
    logic                 MEM_WEB;
    logic [DATA_W-1:0]    MEM_IDATA;
    logic [NM-1:0]        MEM_CSB;
    logic [NM-1:0]        MEM_OEB;
    logic [NM*DATA_W-1:0] MEM_RDATA;
    logic [DATA_W-1:0]    RDATA;
    logic                 RDATA_VALID;

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_LEN, REQ_WDATA, MEM_RDATA,
        output REQ_READY, BEAT_ACK, BUSY, MEM_ADDR, MEM_CE, MEM_WEB, MEM_IDATA,
               MEM_CSB, MEM_OEB, RDATA, RDATA_VALID
    );

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_LEN, REQ_WDATA, MEM_RDATA,
        input  REQ_READY, BEAT_ACK, BUSY, MEM_ADDR, MEM_CE, MEM_WEB, MEM_IDATA,
               MEM_CSB, MEM_OEB, RDATA, RDATA_VALID
    );
endinterface

// File: rtl/mem_bank_ctrl.sv
// rtl/mem_bank_ctrl.sv - SRAM bank controller with request handshake, incrementing bursts and read return
module mem_bank_ctrl #(
    parameter int DATA_W         = 8,
    parameter int MACRO_AW       = 10,
    parameter int MACRO_PER_BANK = 16,
    parameter int NUM_BANKS      = 4,
    parameter int RD_LAT         = 1,
    parameter int LEN_W          = 4
) (
    input  logic CLK,
    input  logic RSTN,
    mem_bank_ctrl_if.slave bus
);
    localparam int NM     = NUM_BANKS * MACRO_PER_BANK;
    localparam int SEL_W  = $clog2(NM);
    localparam int ADDR_W = MACRO_AW + SEL_W;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;

    logic                beat;
    logic                beat_we;
    logic [ADDR_W-1:0]   beat_addr;
    logic [SEL_W-1:0]    beat_sel;
    logic [NM-1:0]       beat_onehot;

    logic [MACRO_AW-1:0] mem_addr_q;
    logic                mem_ce_q;
    logic                mem_web_q;
    logic [DATA_W-1:0]   mem_idata_q;
    logic [NM-1:0]       mem_csb_q;
    logic [NM-1:0]       mem_oeb_q;
    logic                pin_rd_q;
    logic [SEL_W-1:0]    pin_sel_q;

    logic [RD_LAT-1:0]   pipe_v;
    logic [SEL_W-1:0]    pipe_sel [RD_LAT];
    logic [DATA_W-1:0]   rd_words [NM];
    logic [DATA_W-1:0]   rdata_q;
    logic                rdata_valid_q;

    // Bank and macro fields are contiguous above the word field, so together they form the flat macro index.
    assign beat_sel    = beat_addr[ADDR_W-1:MACRO_AW];
    assign beat_onehot = NM'(1) << beat_sel;

    always_comb begin
        state_d   = state_q;
        beat      = 1'b0;
        beat_we   = we_q;
        beat_addr = addr_q + ADDR_W'(1);
        case (state_q)
            IDLE: begin
                beat      = bus.REQ_VALID;
                beat_we   = bus.REQ_WE;
                beat_addr = bus.REQ_ADDR;
                if (bus.REQ_VALID && bus.REQ_LEN != '0) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                beat = 1'b1;
                if (cnt_q == len_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (beat) begin
                addr_q <= beat_addr;
            end
            if (state_q == IDLE && beat) begin
                we_q  <= bus.REQ_WE;
                len_q <= bus.REQ_LEN;
                cnt_q <= LEN_W'(1);
            end else if (state_q == BURST) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

    // Strobes are rebuilt every cycle so idle macros never keep a stale select.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            mem_addr_q  <= '0;
            mem_ce_q    <= 1'b0;
            mem_web_q   <= 1'b1;
            mem_idata_q <= '0;
            mem_csb_q   <= '1;
            mem_oeb_q   <= '1;
            pin_rd_q    <= 1'b0;
            pin_sel_q   <= '0;
        end else if (beat) begin
            mem_addr_q  <= beat_addr[MACRO_AW-1:0];
            mem_ce_q    <= 1'b1;
            mem_web_q   <= ~beat_we;
            mem_idata_q <= bus.REQ_WDATA;
            mem_csb_q   <= ~beat_onehot;
            mem_oeb_q   <= beat_we ? '1 : ~beat_onehot;
            pin_rd_q    <= ~beat_we;
            pin_sel_q   <= beat_sel;
        end else begin
            mem_ce_q    <= 1'b0;
            mem_web_q   <= 1'b1;
            mem_csb_q   <= '1;
            mem_oeb_q   <= '1;
            pin_rd_q    <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            rd_words[i] = bus.MEM_RDATA[i*DATA_W +: DATA_W];
        end
    end

    // Tracks each pin-cycle read through the macro latency so its data is picked from the right slice.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pipe_v        <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_sel[i] <= '0;
            end
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            pipe_v[0]   <= pin_rd_q;
            pipe_sel[0] <= pin_sel_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_sel[i] <= pipe_sel[i-1];
            end
            rdata_valid_q <= pipe_v[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) begin
                rdata_q <= rd_words[pipe_sel[RD_LAT-1]];
            end
        end
    end

    assign bus.REQ_READY   = (state_q == IDLE);
    assign bus.BEAT_ACK    = beat;
    assign bus.BUSY        = (state_q == BURST);
    assign bus.MEM_ADDR    = mem_addr_q;
    assign bus.MEM_CE      = mem_ce_q;
    assign bus.MEM_WEB     = mem_web_q;
    assign bus.MEM_IDATA   = mem_idata_q;
    assign bus.MEM_CSB     = mem_csb_q;
    assign bus.MEM_OEB     = mem_oeb_q;
    assign bus.RDATA       = rdata_q;
    assign bus.RDATA_VALID = rdata_valid_q;
endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb/tb_mem_bank_ctrl.sv - directed bench for mem_bank_ctrl with a cycle-level behavioural model
module tb_mem_bank_ctrl;
    localparam int DATA_W = 8;
    localparam int MACRO_AW = 10;
    localparam int MPB = 16;
    localparam int NB = 4;
    localparam int RD_LAT = 1;
    localparam int LEN_W = 4;
    localparam int NM = NB * MPB;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    always #5 CLK = ~CLK;

    mem_bank_ctrl_if #(.DATA_W(DATA_W), .MACRO_AW(MACRO_AW), .MACRO_PER_BANK(MPB),
                       .NUM_BANKS(NB), .LEN_W(LEN_W)) bus ();

    mem_bank_ctrl #(.DATA_W(DATA_W), .MACRO_AW(MACRO_AW), .MACRO_PER_BANK(MPB),
                    .NUM_BANKS(NB), .RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] pat [NM];
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            bus.MEM_RDATA[i*DATA_W +: DATA_W] = pat[i];
        end
    end

    // Behavioural model: remaining-beat counter plus a queue of read returns stamped with their due cycle.
    typedef struct { int due; int idx; } ret_t;
    ret_t retq[$];
    int cyc = 0;
    int rem = 0;
    logic [15:0] nxt = '0;
    logic bwe = 1'b0;
    logic m_have;
    logic [15:0] m_a;
    logic m_w;
    logic e_ce = 1'b0, e_web = 1'b1, e_rv = 1'b0;
    logic [9:0] e_addr = '0;
    logic [7:0] e_idata = '0, e_rdata = '0;
    logic [63:0] e_csb = ALL1, e_oeb = ALL1;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rem = 0; nxt = '0; bwe = 1'b0;
            e_ce = 1'b0; e_web = 1'b1; e_addr = '0; e_idata = '0;
            e_csb = ALL1; e_oeb = ALL1; e_rv = 1'b0; e_rdata = '0;
            retq.delete();
        end else begin
            cyc++;
            e_rv = 1'b0;
            if (retq.size() > 0 && retq[0].due == cyc) begin
                e_rv = 1'b1;
                e_rdata = pat[retq[0].idx];
                void'(retq.pop_front());
            end
            m_have = 1'b0;
            if (rem > 0) begin
                m_have = 1'b1; m_a = nxt; m_w = bwe; rem--;
            end else if (bus.REQ_VALID) begin
                m_have = 1'b1; m_a = bus.REQ_ADDR; m_w = bus.REQ_WE;
                bwe = bus.REQ_WE; rem = int'(bus.REQ_LEN);
            end
            if (m_have) begin
                nxt = m_a + 16'd1;
                e_ce = 1'b1;
                e_web = !m_w;
                e_addr = 10'(m_a % 1024);
                e_idata = bus.REQ_WDATA;
                e_csb = ~(64'd1 << (m_a / 1024));
                e_oeb = m_w ? ALL1 : e_csb;
                if (!m_w) retq.push_back('{cyc + RD_LAT + 1, int'(m_a / 1024)});
            end else begin
                e_ce = 1'b0; e_web = 1'b1; e_csb = ALL1; e_oeb = ALL1;
            end
        end
    end

    always @(negedge CLK) begin
        check("m_ready", bus.REQ_READY, rem == 0);
        check("m_busy", bus.BUSY, rem != 0);
        check("m_beat_ack", bus.BEAT_ACK, (rem == 0 && bus.REQ_VALID) || rem != 0);
        check("m_ce", bus.MEM_CE, e_ce);
        check("m_web", bus.MEM_WEB, e_web);
        check("m_addr", bus.MEM_ADDR, e_addr);
        check("m_idata", bus.MEM_IDATA, e_idata);
        check("m_csb", bus.MEM_CSB, e_csb);
        check("m_oeb", bus.MEM_OEB, e_oeb);
        check("m_rvalid", bus.RDATA_VALID, e_rv);
        if (e_rv || !RSTN) check("m_rdata", bus.RDATA, e_rdata);
    end

    logic [7:0] got_q[$];
    always @(negedge CLK) begin
        if (bus.RDATA_VALID) got_q.push_back(bus.RDATA);
    end

    task automatic drive(input logic v, input logic we, input logic [15:0] a,
                         input logic [3:0] len, input logic [7:0] wd);
        bus.REQ_VALID = v; bus.REQ_WE = we; bus.REQ_ADDR = a; bus.REQ_LEN = len; bus.REQ_WDATA = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    logic [15:0] b2b_addr [4];
    logic [7:0]  b2b_exp [4];
    logic [9:0]  wr_addr [4];
    logic [63:0] wr_csb [4];
    logic [7:0]  wr_exp [4];

    initial begin
        for (int i = 0; i < NM; i++) pat[i] = 8'(i * 5 + 8'h11);
        pat[19] = 8'h3C;
        drive(1'b0, 1'b0, 16'h0, 4'h0, 8'h0);
        RSTN = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_csb", bus.MEM_CSB, ALL1);
        check("rst_oeb", bus.MEM_OEB, ALL1);
        check("rst_ce", bus.MEM_CE, 1'b0);
        check("rst_web", bus.MEM_WEB, 1'b1);
        check("rst_ready", bus.REQ_READY, 1'b1);
        check("rst_rvalid", bus.RDATA_VALID, 1'b0);
        #1 RSTN = 1'b1;
        @(negedge CLK); #1;

        drive(1'b1, 1'b1, 16'h4C05, 4'h0, 8'hA5);
        @(negedge CLK);
        check("wr_ce", bus.MEM_CE, 1'b1);
        check("wr_web", bus.MEM_WEB, 1'b0);
        check("wr_addr", bus.MEM_ADDR, 10'h005);
        check("wr_idata", bus.MEM_IDATA, 8'hA5);
        check("wr_csb", bus.MEM_CSB, 64'hFFFF_FFFF_FFF7_FFFF);
        check("wr_oeb", bus.MEM_OEB, ALL1);
        #1 drive(1'b0, 1'b0, 16'h4C05, 4'h0, 8'hA5);
        @(negedge CLK);
        check("wr_idle_ce", bus.MEM_CE, 1'b0);
        check("wr_idle_csb", bus.MEM_CSB, ALL1);
        #1;

        drive(1'b1, 1'b0, 16'h4C05, 4'h0, 8'h00);
        @(negedge CLK);
        check("rd_csb", bus.MEM_CSB, 64'hFFFF_FFFF_FFF7_FFFF);
        check("rd_oeb", bus.MEM_OEB, 64'hFFFF_FFFF_FFF7_FFFF);
        #1 bus.REQ_VALID = 1'b0;
        @(negedge CLK);
        check("rd_rvalid_early", bus.RDATA_VALID, 1'b0);
        @(negedge CLK);
        check("rd_rvalid", bus.RDATA_VALID, 1'b1);
        check("rd_rdata", bus.RDATA, 8'h3C);
        #1;

        b2b_addr = '{16'h0012, 16'h4421, 16'h88AB, 16'hFFFF};
        b2b_exp  = '{8'h11, 8'h66, 8'hBB, 8'h4C};
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            check("b2b_ready", bus.REQ_READY, 1'b1);
            drive(1'b1, 1'b0, b2b_addr[i], 4'h0, 8'h00);
            @(negedge CLK); #1;
        end
        bus.REQ_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        #1;
        check("b2b_count", got_q.size(), 4);
        if (got_q.size() == 4)
            for (int i = 0; i < 4; i++) check("b2b_rdata", got_q[i], b2b_exp[i]);

        wr_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        wr_csb  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
        got_q.delete();
        drive(1'b1, 1'b0, 16'hFFFE, 4'h3, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("wrap_addr", bus.MEM_ADDR, wr_addr[k]);
            check("wrap_csb", bus.MEM_CSB, wr_csb[k]);
            check("wrap_busy", bus.BUSY, k < 3);
            check("wrap_ready", bus.REQ_READY, k == 3);
            #1 bus.REQ_VALID = 1'b0;
        end
        repeat (4) @(negedge CLK);
        #1;
        b2b_exp = '{8'h4C, 8'h4C, 8'h11, 8'h11};
        check("wrap_count", got_q.size(), 4);
        if (got_q.size() == 4)
            for (int i = 0; i < 4; i++) check("wrap_rdata", got_q[i], b2b_exp[i]);

        wr_exp = '{8'h10, 8'h11, 8'h12, 8'h00};
        drive(1'b1, 1'b1, 16'h07FE, 4'h2, 8'h10);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("wburst_idata", bus.MEM_IDATA, wr_exp[k]);
            check("wburst_oeb", bus.MEM_OEB, ALL1);
            #1;
            bus.REQ_VALID = 1'b0;
            bus.REQ_WDATA = 8'h11 + 8'(k);
        end
        check("wburst_last_csb", bus.MEM_CSB, 64'hFFFF_FFFF_FFFF_FFFB);
        @(negedge CLK); #1;

        drive(1'b1, 1'b0, 16'h1000, 4'h7, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1;
            bus.REQ_VALID = 1'b0;
        end
        RSTN = 1'b0;
        got_q.delete();
        #1;
        check("mrst_ce", bus.MEM_CE, 1'b0);
        check("mrst_web", bus.MEM_WEB, 1'b1);
        check("mrst_addr", bus.MEM_ADDR, 10'h000);
        check("mrst_csb", bus.MEM_CSB, ALL1);
        check("mrst_oeb", bus.MEM_OEB, ALL1);
        check("mrst_busy", bus.BUSY, 1'b0);
        check("mrst_rvalid", bus.RDATA_VALID, 1'b0);
        repeat (2) @(negedge CLK);
        #1 RSTN = 1'b1;
        repeat (6) @(negedge CLK);
        check("mrst_no_return", got_q.size(), 0);
        #1;

        drive(1'b1, 1'b0, 16'h4C05, 4'h0, 8'h00);
        @(negedge CLK);
        check("post_ce", bus.MEM_CE, 1'b1);
        #1 bus.REQ_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("post_rvalid", bus.RDATA_VALID, 1'b1);
        check("post_rdata", bus.RDATA, 8'h3C);
        repeat (2) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bank_ctrl.md
Name: mem_bank_ctrl

Overview:
Parametrised SRAM bank controller. It decodes a flat request address into bank, macro and word fields and drives registered per-macro chip-select and output-enable strobes (active-low) to an array of NUM_BANKS x MACRO_PER_BANK SRAM macros. Compared with the first-generation fixed 4x16 decoder it adds three things: a valid/ready request handshake, incrementing bursts, and a read-return path that muxes the selected macro's data back with a valid strobe. It sits between the bus-side memory interface and the SRAM macro array.

Parameters:
DATA_W, 8, macro data width
MACRO_AW, 10, word address bits per macro (depth 2^MACRO_AW)
MACRO_PER_BANK, 16, macros per bank (power of 2)
NUM_BANKS, 4, bank count (power of 2)
RD_LAT, 1, macro read latency in cycles (>=1), from strobed pin cycle to MEM_RDATA valid
LEN_W, 4, burst length field width
Derived:
- NM = NUM_BANKS*MACRO_PER_BANK
- ADDR_W = MACRO_AW + log2(MACRO_PER_BANK) + log2(NUM_BANKS)
- Default ADDR_W = 16

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  request accepted when VALID&READY at a rising edge
REQ_WE  in  1  1=write, 0=read
REQ_ADDR  in  ADDR_W  start address; [MSBs]=bank, [mid]=macro, [MACRO_AW-1:0]=word
REQ_LEN  in  LEN_W  beats minus 1
REQ_WDATA  in  DATA_W  write data, sampled on every BEAT_ACK cycle
BEAT_ACK  out  1  (comb.) REQ_WDATA consumed this cycle
BUSY  out  1  burst in progress
MEM_ADDR  out  MACRO_AW  word address to all macros
MEM_CE  out  1  1 = access cycle
MEM_WEB  out  1  0 = write
MEM_IDATA  out  DATA_W  write data to all macros
MEM_CSB  out  NM  per-macro chip select, active-low; index = bank*MACRO_PER_BANK+macro
MEM_OEB  out  NM  per-macro output enable, active-low
MEM_RDATA  in  NM*DATA_W  flattened macro read data, macro i at [i*DATA_W +: DATA_W]
RDATA  out  DATA_W  returned read data
RDATA_VALID  out  1  RDATA valid, one pulse per read beat

Behaviour:
- Reset values (async on RSTN low, regardless of state):
  - MEM_ADDR=0, MEM_CE=0, MEM_WEB=1, MEM_IDATA=0
  - MEM_CSB and MEM_OEB all 1s
  - RDATA=0, RDATA_VALID=0, BUSY=0
  - state=IDLE, beat counter=0
  - read-select pipeline cleared
- Reset mid-burst abandons the burst: no further strobes, no RDATA_VALID for in-flight reads.
- FSM states: IDLE, BURST.
  - REQ_READY = (state==IDLE), combinational from the registered state.
  - BEAT_ACK = (IDLE & REQ_VALID) | BURST.
  - BUSY = BURST.
- IDLE, accept with REQ_LEN==0: issue one beat and stay in IDLE. Single accesses can therefore be accepted every cycle.
- IDLE, accept with REQ_LEN>0:
  - Issue beat 0.
  - Latch REQ_WE, the start address and the length.
  - Go to BURST.
- BURST:
  - Issue one beat per cycle at address base+k (k = 1..LEN).
  - Each write beat uses the current REQ_WDATA.
  - REQ_VALID, REQ_ADDR and REQ_LEN are ignored.
  - After the beat with k==LEN, return to IDLE.
- Address increment is modulo 2^ADDR_W: all-ones wraps to 0. A burst crosses macro and bank boundaries freely; each beat is decoded independently.
- Beat issue timing: a beat decided in cycle C is registered at the end of C and appears on the MEM_* pins in cycle C+1. Pin values for a beat:
  - MEM_CE=1
  - MEM_WEB=~we
  - MEM_ADDR=word field
  - MEM_IDATA=data
  - MEM_CSB: only the selected bit is 0
  - MEM_OEB: only the selected bit is 0 for reads; all 1s for writes
- Any cycle with no beat: MEM_CE=0, MEM_WEB=1, all CSB/OEB=1. MEM_ADDR and MEM_IDATA hold their last values. Unlike the previous generation, strobes of idle banks do not hold stale values.
- Read return:
  - Each read beat pushes {valid, macro index} into a shift pipeline of depth RD_LAT.
  - At pipeline output, RDATA is registered from the MEM_RDATA slice of that index, and RDATA_VALID is asserted for that one cycle.
  - Read beat on pins in cycle P gives RDATA/RDATA_VALID in cycle P+RD_LAT+1.
  - Writes push valid=0.
- Read data returns in issue order. There is no backpressure on RDATA.

Test Plan:
- Reset then idle (defaults, RD_LAT=1): CSB/OEB=16'hFFFF per bank (64 ones), MEM_CE=0, MEM_WEB=1, REQ_READY=1, RDATA_VALID=0.
- Single write: addr 16'h4C05 (bank 1, macro 3, word 5), data 8'hA5, accepted at edge 0. Next cycle: MEM_CE=1, MEM_WEB=0, MEM_ADDR=5, MEM_IDATA=A5, CSB bit 19=0 and all other CSB bits 1, OEB all 1. The following cycle returns to the idle defaults.
- Single read: addr 16'h4C05, MEM_RDATA macro 19 = 8'h3C. OEB and CSB bit 19 are low for one cycle; RDATA=3C with RDATA_VALID=1 exactly 2 cycles later.
- Back-to-back reads: 4 single reads to macros 0, 17, 34, 63 on consecutive cycles, with REQ_READY held at 1 throughout. Four consecutive RDATA_VALID pulses return each macro's data in order.
- Burst wrap: read at addr 16'hFFFE, LEN=3. REQ_READY=0 and BUSY=1 for 3 cycles. Word addresses seen are 3FE, 3FF, 000, 001; CSB bits go 63, 63, 0, 0. Four valid returns follow.
- Reset mid-burst: read LEN=7, RSTN asserted after beat 2. All outputs return to reset values immediately and no RDATA_VALID occurs after release. A new single request is accepted normally.
